// File: rtl/rom_stream_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rom_stream_reader_pkg
// Purpose  : Shared definitions for the ROM stream reader. Holds the
//            sequencer state encoding and the address/data width defaults
//            that the reader shares with the ROM it drives.
// Contents : state_t        - sequencer FSM states
//            c_ROM_ADDR_W   - default ROM address width
//            c_ROM_DATA_W   - default ROM word width
// Revision : 1.0 - initial release
// ============================================================================
package rom_stream_reader_pkg;

  localparam int unsigned c_ROM_ADDR_W = 4;
  localparam int unsigned c_ROM_DATA_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rom_stream_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : rom_stream_reader_if
// Purpose  : Valid/ready output stream of the ROM stream reader.
// Signals  : m_data  - stream word
//            m_valid - word present
//            m_ready - downstream accepts the word
//            m_last  - final word of a command
// Modports : master - stream source (reader)
//            slave  - stream sink
// Revision : 1.0 - initial release
// ============================================================================
interface rom_stream_reader_if
  import rom_stream_reader_pkg::*;
#(
  parameter int unsigned DATA_W = c_ROM_DATA_W
);

  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready
  );

endinterface
`default_nettype wire

// File: rtl/rom_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rom_skid_fifo
// Purpose  : Small synchronous FIFO that absorbs ROM read data while the
//            downstream stream is stalled. Head entry is presented directly
//            from storage; a push and a pop may occur in the same cycle.
// Ports    : clk, rst - clock, synchronous active-high reset (flushes)
//            i_push   - write i_data (ignored when full and not popping)
//            i_data   - entry to write
//            i_pop    - drop the head entry (ignored when empty)
//            o_data   - head entry
//            o_occ    - number of stored entries
// Revision : 1.0 - initial release
// ============================================================================
module rom_skid_fifo #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DEPTH = 2
) (
  input  wire                        clk,
  input  wire                        rst,
  input  wire                        i_push,
  input  wire  [WIDTH-1:0]           i_data,
  input  wire                        i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_occ
);

  localparam int unsigned c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned c_OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_OCC_W-1:0] r_occ;
  logic               w_do_pop;
  logic               w_do_push;

  // Pointer advance with explicit wrap so non power-of-two depths work.
  function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
  endfunction

  assign w_do_pop  = i_pop && (r_occ != '0);
  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign w_do_push = i_push && ((r_occ != c_OCC_W'(DEPTH)) || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      if (w_do_push && !w_do_pop) begin
        r_occ <= r_occ + c_OCC_W'(1);
      end else if (!w_do_push && w_do_pop) begin
        r_occ <= r_occ - c_OCC_W'(1);
      end
    end
  end

  assign o_data = r_mem[r_rd_ptr];
  assign o_occ  = r_occ;

endmodule
`default_nettype wire

// File: rtl/rom_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : rom_stream_reader
// Purpose  : Sequencer in front of a single-port ROM with a 1-cycle
//            registered read. On a start command it reads a contiguous,
//            wrapping address range and streams the words out on a
//            valid/ready interface, buffering through a small skid FIFO.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            i_start       - command strobe (sampled only when idle)
//            i_base_addr   - first address of the command
//            i_count       - number of words, 0..2^ADDR_W
//            o_busy        - command in progress
//            o_done        - one-cycle completion pulse
//            o_rom_en      - ROM read enable
//            o_rom_addr    - ROM address
//            i_rom_dout    - ROM read data
//            m_if          - output stream (master modport)
// Revision : 1.0 - initial release
// ============================================================================
module rom_stream_reader
  import rom_stream_reader_pkg::*;
#(
  parameter int unsigned ADDR_W     = c_ROM_ADDR_W,
  parameter int unsigned DATA_W     = c_ROM_DATA_W,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  wire                 clk,
  input  wire                 rst,
  input  wire                 i_start,
  input  wire  [ADDR_W-1:0]   i_base_addr,
  input  wire  [ADDR_W:0]     i_count,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_rom_en,
  output logic [ADDR_W-1:0]   o_rom_addr,
  input  wire  [DATA_W-1:0]   i_rom_dout,
  rom_stream_reader_if.master m_if
);

  localparam int unsigned c_OCC_W = $clog2(FIFO_DEPTH + 1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cur_addr;
  logic [ADDR_W:0]     r_remaining;
  logic                r_pending;       // ROM read issued last cycle
  logic                r_pending_last;  // that read is the command's final word
  logic                r_busy;
  logic                r_done;

  logic [c_OCC_W-1:0]  w_occ;
  logic [c_OCC_W:0]    w_inflight;
  logic                w_pop;
  logic                w_issue;
  logic                w_final;
  logic                w_drain_empty;
  logic [DATA_W:0]     w_head;

  assign w_pop = m_if.m_valid && m_if.m_ready;

  // Words already owned by the FIFO or still in the ROM pipeline, after this
  // cycle's pop. A new read is only issued when it is guaranteed a slot.
  assign w_inflight = {1'b0, w_occ} + (c_OCC_W + 1)'(r_pending) - (c_OCC_W + 1)'(w_pop);

  assign w_issue = (r_state == ST_READ) && (r_remaining != '0) &&
                   (w_inflight < (c_OCC_W + 1)'(FIFO_DEPTH));
  assign w_final = w_issue && (r_remaining == (ADDR_W + 1)'(1));

  // Finish as soon as the last word leaves: nothing in flight, and the FIFO
  // is either empty or losing its only entry this cycle.
  assign w_drain_empty = !r_pending &&
                         ((w_occ == '0) || ((w_occ == c_OCC_W'(1)) && w_pop));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_cur_addr     <= '0;
      r_remaining    <= '0;
      r_pending      <= 1'b0;
      r_pending_last <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_pending      <= w_issue;
      r_pending_last <= w_final;
      r_done         <= 1'b0;

      if (w_issue) begin
        r_cur_addr  <= r_cur_addr + ADDR_W'(1);
        r_remaining <= r_remaining - (ADDR_W + 1)'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            if (i_count != '0) begin
              r_cur_addr  <= i_base_addr;
              r_remaining <= i_count;
              r_busy      <= 1'b1;
              r_state     <= ST_READ;
            end else begin
              // Empty command completes immediately without touching the ROM.
              r_done <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (w_final) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_drain_empty) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // The ROM drives undefined data when not enabled, so only cycles that
  // follow an issued read push into the FIFO.
  rom_skid_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (r_pending),
    .i_data ({r_pending_last, i_rom_dout}),
    .i_pop  (w_pop),
    .o_data (w_head),
    .o_occ  (w_occ)
  );

  assign m_if.m_valid = (w_occ != '0);
  assign m_if.m_data  = w_head[DATA_W-1:0];
  assign m_if.m_last  = w_head[DATA_W];

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_rom_en   = w_issue;
  assign o_rom_addr = r_cur_addr;

endmodule
`default_nettype wire

// File: tb/tb_rom_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_stream_reader
// Purpose  : Self-checking bench for rom_stream_reader with a behavioural
//            ROM (mem[i] = i, 1-cycle registered read). Expected stream
//            words are queued when a command is issued; a monitor compares
//            every presented word against the queue head.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_stream_reader;

  localparam int AW    = 4;
  localparam int DW    = 4;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   count = '0;
  logic          busy;
  logic          done;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_dout;

  int checks   = 0;
  int failures = 0;
  int outstanding = 0;
  logic mon_pop;
  logic [DW:0] exp_q[$];

  always #5 clk = ~clk;

  rom_stream_reader_if #(.DATA_W(DW)) m_if ();

  rom_stream_reader #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (start),
    .i_base_addr (base_addr),
    .i_count     (count),
    .o_busy      (busy),
    .o_done      (done),
    .o_rom_en    (rom_en),
    .o_rom_addr  (rom_addr),
    .i_rom_dout  (rom_dout),
    .m_if        (m_if)
  );

  // ROM model: mem[i] = i, undefined output when not enabled.
  always @(posedge clk) begin
    if (rst)         rom_dout <= '0;
    else if (rom_en) rom_dout <= rom_addr;
    else             rom_dout <= 'x;
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Stream scoreboard plus ROM-enable gating model.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      outstanding = 0;
    end else begin
      mon_pop = m_if.m_valid && m_if.m_ready;
      if (m_if.m_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_word: got data=%0d last=%0d, queue empty",
                   m_if.m_data, m_if.m_last);
        end else if ({m_if.m_last, m_if.m_data} !== exp_q[0]) begin
          failures++;
          $display("FAIL stream_word: got data=%0d last=%0d expected data=%0d last=%0d",
                   m_if.m_data, m_if.m_last, exp_q[0][DW-1:0], exp_q[0][DW]);
        end
        if (mon_pop && exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (rom_en) begin
        checks++;
        if (!busy || (outstanding - int'(mon_pop)) >= DEPTH) begin
          failures++;
          $display("FAIL rom_en_gate: rom_en=1 with busy=%0d inflight=%0d pop=%0d",
                   busy, outstanding, mon_pop);
        end
      end
      outstanding = outstanding + int'(rom_en) - int'(mon_pop);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: always ready; 1: pattern 1,0,0,1; 2: stalled until cycle 6.
  function automatic logic ready_fn(input int mode, input int rel);
    case (mode)
      1:       return ((rel % 4) == 0) || ((rel % 4) == 3);
      2:       return rel >= 6;
      default: return 1'b1;
    endcase
  endfunction

  task automatic check_idle(input string name);
    chk({name, "_busy"},     int'(busy), 0);
    chk({name, "_done"},     int'(done), 0);
    chk({name, "_rom_en"},   int'(rom_en), 0);
    chk({name, "_rom_addr"}, int'(rom_addr), 0);
    chk({name, "_m_valid"},  int'(m_if.m_valid), 0);
    chk({name, "_m_last"},   int'(m_if.m_last), 0);
    chk({name, "_m_data"},   int'(m_if.m_data), 0);
  endtask

  // Issue one command in the current cycle (cycle 0) and follow it.
  // exp_done < 0: only require that done arrives. rst_at >= 0: reset in that
  // cycle and return. inj_at >= 0: assert a second start in that cycle.
  task automatic run_cmd(input string name, input int base, input int cnt,
                         input int mode, input int exp_done,
                         input int rst_at, input int inj_at);
    logic [DW:0]   e;
    logic [AW-1:0] exp_addr;
    int            n_en;
    int            done_rel;
    bit            got_done;
    for (int i = 0; i < cnt; i++) begin
      e[DW-1:0] = DW'(base + i);
      e[DW]     = (i == cnt - 1);
      exp_q.push_back(e);
    end
    start     = 1'b1;
    base_addr = AW'(base);
    count     = (AW + 1)'(cnt);
    m_if.m_ready = ready_fn(mode, 0);
    exp_addr  = AW'(base);
    n_en      = 0;
    done_rel  = -1;
    got_done  = 1'b0;
    for (int rel = 1; rel <= 150 && !got_done; rel++) begin
      tick();
      start = 1'b0;
      if (rel == inj_at) begin
        start     = 1'b1;
        base_addr = AW'(0);
        count     = (AW + 1)'(5);
      end
      m_if.m_ready = ready_fn(mode, rel);
      #1;
      if (rel == rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_idle({name, "_after_reset"});
        return;
      end
      if (mode == 0) begin
        chk({name, "_rom_en"},  int'(rom_en), int'(rel >= 1 && rel <= cnt));
        chk({name, "_m_valid"}, int'(m_if.m_valid), int'(rel >= 3 && rel <= cnt + 2));
      end else if (mode == 2) begin
        chk({name, "_m_valid"}, int'(m_if.m_valid), int'(rel >= 3 && rel <= 6));
      end
      if (rom_en) begin
        chk({name, "_rom_addr"}, int'(rom_addr), int'(exp_addr));
        exp_addr = exp_addr + AW'(1);
        n_en++;
      end
      if (done) begin
        got_done = 1'b1;
        done_rel = rel;
        chk({name, "_busy_at_done"}, int'(busy), 0);
      end
    end
    chk({name, "_done_seen"}, int'(got_done), 1);
    if (exp_done >= 0) chk({name, "_done_cycle"}, done_rel, exp_done);
    chk({name, "_rom_reads"}, n_en, cnt);
    tick();
    chk({name, "_done_pulse_end"}, int'(done), 0);
    chk({name, "_idle_valid"},     int'(m_if.m_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_if.m_ready = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check_idle("reset");

    run_cmd("basic",     3,  4, 0,  7, -1, -1);
    run_cmd("wrap",      14, 4, 0,  7, -1, -1);
    run_cmd("full_bp",   0, 16, 1, -1, -1, -1);
    run_cmd("count0",    5,  0, 0,  1, -1, -1);
    run_cmd("start_busy", 5, 3, 0,  6, -1,  2);
    run_cmd("rst_mid",   0,  8, 0, -1,  5, -1);
    run_cmd("after_rst", 9,  2, 0,  5, -1, -1);
    run_cmd("single",    7,  1, 2,  7, -1, -1);

    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
